// File: rtl/root_pkg.sv
// root_pkg: flit type codes, arbitration pointer encoding and flit width derivation
package root_pkg;
  typedef enum logic [1:0] {
    FT_WRITE     = 2'b00,
    FT_READ_REQ  = 2'b01,
    FT_READ_RESP = 2'b10,
    FT_DONE      = 2'b11
  } flit_type_t;
  typedef enum logic {RR_WRITE = 1'b0, RR_READ = 1'b1} rr_t;
  localparam int TYPE_W = 2;
  function automatic int flit_width(input int addr_w, input int data_w);
    return TYPE_W + addr_w + data_w;
  endfunction
endpackage

// File: rtl/root_resp_fifo.sv
// root_resp_fifo: synchronous FIFO that accepts a push when full if a pop happens in the same cycle
module root_resp_fifo #(
  parameter int W = 34,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/root_host_bridge.sv
// root_host_bridge: host-to-router root endpoint with credit flow control, read tracking and done interrupt
module root_host_bridge
  import root_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int CREDIT_INIT = 4,
  parameter int RESP_DEPTH = 4,
  parameter int MAX_OUT = 4,
  parameter int NUM_LEAVES = 16,
  localparam int FLIT_W = flit_width(ADDR_W, DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              interrupt,
  input  logic              intr_clear,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic              write_rdy,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] read_addr,
  output logic              read_rdy,
  output logic              read_data_vld,
  output logic [DATA_W-1:0] read_data,
  input  logic              read_data_rdy,
  output logic              out_data_valid,
  output logic [FLIT_W-1:0] out_data,
  input  logic              downstream_credit,
  input  logic              in_data_valid,
  input  logic [FLIT_W-1:0] in_data,
  output logic              upstream_credit
);
  localparam int CW = $clog2(CREDIT_INIT + 1);
  localparam int DW = $clog2(NUM_LEAVES + 1);
  localparam int QW = $clog2(RESP_DEPTH) + 1;
  logic [CW-1:0] credit_cnt;
  logic [3:0] out_cnt;
  logic [DW-1:0] done_cnt;
  rr_t rr_ptr;
  logic can_send, rd_ok, acc_w, acc_r, acc, pop, full, empty, head_resp, head_done, set_intr;
  logic [FLIT_W-1:0] head;
  logic [QW-1:0] count;
  flit_type_t head_type;
  assign can_send = credit_cnt != '0;
  assign rd_ok = out_cnt < 4'(MAX_OUT);
  assign write_rdy = can_send & (!read_en | !rd_ok | rr_ptr == RR_WRITE);
  assign read_rdy = can_send & rd_ok & (!write_en | rr_ptr == RR_READ);
  assign acc_w = write_en & write_rdy;
  assign acc_r = read_en & read_rdy;
  assign acc = acc_w | acc_r;
  assign head_type = flit_type_t'(head[FLIT_W-1 -: TYPE_W]);
  assign head_resp = !empty & head_type == FT_READ_RESP;
  assign head_done = !empty & head_type == FT_DONE;
  // Responses wait for the host; everything else drains the cycle it reaches the head
  assign pop = !empty & (!head_resp | read_data_rdy);
  assign read_data_vld = head_resp;
  assign read_data = head_resp ? head[DATA_W-1:0] : '0;
  assign set_intr = pop & head_done & done_cnt == DW'(NUM_LEAVES - 1);
  root_resp_fifo #(.W(FLIT_W), .DEPTH(RESP_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(in_data_valid), .din(in_data), .pop(pop),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  always_ff @(posedge clk)
    if (rst) begin
      credit_cnt <= CW'(CREDIT_INIT);
      out_cnt <= '0;
      done_cnt <= '0;
      rr_ptr <= RR_WRITE;
      interrupt <= 1'b0;
      out_data_valid <= 1'b0;
      out_data <= '0;
      upstream_credit <= 1'b0;
    end else begin
      credit_cnt <= credit_cnt - CW'(acc) + CW'(downstream_credit & (acc | credit_cnt != CW'(CREDIT_INIT)));
      out_cnt <= out_cnt + 4'(acc_r) - 4'(pop & head_resp);
      if (pop & head_done) done_cnt <= set_intr ? '0 : done_cnt + DW'(1);
      if (write_en & read_en & acc) rr_ptr <= acc_w ? RR_READ : RR_WRITE;
      interrupt <= set_intr | (interrupt & !intr_clear);
      out_data_valid <= acc;
      out_data <= acc ? {acc_w ? FT_WRITE : FT_READ_REQ, acc_w ? write_addr : read_addr, acc_w ? write_data : DATA_W'(0)} : '0;
      upstream_credit <= pop;
    end
  always_ff @(posedge clk)
    if (!rst) begin
      assert (!(downstream_credit & !acc & credit_cnt == CW'(CREDIT_INIT)));
      assert (!(in_data_valid & full & !pop));
      assert (count <= QW'(RESP_DEPTH));
    end
endmodule
